// File: rtl/jt12_acc_mix_pkg.sv
// Shared definitions for the operator accumulator / stereo mixer.
//   - group encoding of the slot sequence S1, S3, S2, S4
//   - carrier mask per algorithm, bits ordered {S1,S3,S2,S4}
//   - saturation limits for the 14-bit channel and 16-bit stereo paths
//   - operator and sample data types
package jt12_acc_mix_pkg;

    localparam logic [1:0] GRP_S1 = 2'd0;
    localparam logic [1:0] GRP_S3 = 2'd1;
    localparam logic [1:0] GRP_S2 = 2'd2;
    localparam logic [1:0] GRP_S4 = 2'd3;

    // Indexed by algorithm; bit 3 = S1, bit 2 = S3, bit 1 = S2, bit 0 = S4.
    localparam logic [3:0] CARRIER_MASK [8] = '{
        4'b0001, 4'b0001, 4'b0001, 4'b0001,
        4'b0011, 4'b0111, 4'b0111, 4'b1111
    };

    localparam int SAT14_MAX = 8191;
    localparam int SAT14_MIN = -8192;
    localparam int SAT16_MAX = 32767;
    localparam int SAT16_MIN = -32768;

    typedef logic signed [13:0] op_t;
    typedef logic signed [15:0] snd_t;

    // Group code 0..3 maps onto mask bit 3..0.
    function automatic logic is_carrier(input logic [2:0] alg, input logic [1:0] grp);
        logic [3:0] mask;
        mask = CARRIER_MASK[alg];
        return mask[2'd3 - grp];
    endfunction

endpackage

// File: rtl/jt12_acc_mix_if.sv
// Slot-rate bus between the operator stage and the accumulator/mixer.
//   master: drives clk_en, zero, op_result, alg, pan, dacen, dac_data
//   slave : drives ch_out, ch_num, ch_valid, snd_left, snd_right, snd_sample
interface jt12_acc_mix_if;
    import jt12_acc_mix_pkg::*;

    logic       clk_en;
    logic       zero;
    op_t        op_result;
    logic [2:0] alg;
    logic [1:0] pan;
    logic       dacen;
    logic [8:0] dac_data;

    op_t        ch_out;
    logic [2:0] ch_num;
    logic       ch_valid;
    snd_t       snd_left;
    snd_t       snd_right;
    logic       snd_sample;

    modport master (
        output clk_en, zero, op_result, alg, pan, dacen, dac_data,
        input  ch_out, ch_num, ch_valid, snd_left, snd_right, snd_sample
    );

    modport slave (
        input  clk_en, zero, op_result, alg, pan, dacen, dac_data,
        output ch_out, ch_num, ch_valid, snd_left, snd_right, snd_sample
    );

endinterface

// File: rtl/jt12_acc_sat.sv
// Signed saturator from in_w bits down to out_w bits.
//   din  : signed input, in_w bits
//   dout : din clamped to the signed out_w range
module jt12_acc_sat #(
    parameter int in_w  = 16,
    parameter int out_w = 14
) (
    input  logic [in_w-1:0]  din,
    output logic [out_w-1:0] dout
);

    // Bits that must all equal the sign for the value to fit unchanged.
    localparam int XW = in_w - out_w + 1;

    logic [XW-1:0] top;
    assign top = din[in_w-1 -: XW];

    // NOTE: dout is assigned on every branch so this stays purely combinational.
    always_comb begin
        if (top == '0 || top == '1) dout = din[out_w-1:0];
        else if (din[in_w-1])       dout = {1'b1, {(out_w-1){1'b0}}};
        else                        dout = {1'b0, {(out_w-1){1'b1}}};
    end

endmodule

// File: rtl/jt12_sh.sv
// Generic multi-stage shift register, advancing on clk_en.
//   clk    : system clock
//   clk_en : shift enable
//   din    : value entering stage 0
//   drop   : value leaving the last stage (written 'stages' enables ago)
module jt12_sh #(
    parameter int width  = 5,
    parameter int stages = 24
) (
    input  logic             clk,
    input  logic             clk_en,
    input  logic [width-1:0] din,
    output logic [width-1:0] drop
);

    logic [width-1:0] bits [stages];

    // NOTE: the storage array has no reset; every consumer overwrites stale
    // contents before using them, and a reset would stop it mapping to plain
    // shift-register cells.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            bits[0] <= din;
            for (int i = 1; i < stages; i++) bits[i] <= bits[i-1];
        end
    end

    assign drop = bits[stages-1];

endmodule

// File: rtl/jt12_acc_mix.sv
// Operator-output accumulator and stereo mixer.
// Sums carrier operators per channel over the 24-slot frame, applies the DAC
// override on channel 5 and panning, and emits per-channel values plus one
// saturated stereo sample per frame.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of jt12_acc_mix_if (slot inputs, channel/sample outputs)
module jt12_acc_mix
    import jt12_acc_mix_pkg::*;
#(
    parameter int num_ch = 6,
    parameter int acc_w  = 19
) (
    input  logic          clk,
    input  logic          rst,
    jt12_acc_mix_if.slave bus
);

    localparam logic [2:0] LAST_CH = 3'(num_ch - 1);

    logic [2:0] ch_cnt, cur_ch;
    logic [1:0] grp_cnt, cur_grp;
    logic       synced, live;

    // ch_cnt/grp_cnt hold the index of the slot taken at the last clk_en;
    // cur_* is the index of the slot presented now. zero forces slot 0.
    always_comb begin
        cur_ch  = ch_cnt + 3'd1;
        cur_grp = grp_cnt;
        if (bus.zero) begin
            cur_ch  = '0;
            cur_grp = GRP_S1;
        end else if (ch_cnt == LAST_CH) begin
            cur_ch  = '0;
            cur_grp = grp_cnt + 2'd1;
        end
    end

    // The zero slot itself is already a valid slot 0.
    assign live = synced | bus.zero;

    // Per-channel partial sums ride a 6-deep buffer: the head is the same
    // channel's sum from the previous group.
    logic signed [15:0] contrib, head, sum16, push;

    assign contrib = is_carrier(bus.alg, cur_grp) ?
                     {{2{bus.op_result[13]}}, bus.op_result} : '0;
    assign sum16   = head + contrib;
    assign push    = (cur_grp == GRP_S1) ? contrib : sum16;

    jt12_sh #(.width(16), .stages(num_ch)) u_buf (
        .clk    (clk),
        .clk_en (bus.clk_en),
        .din    (push),
        .drop   (head)
    );

    op_t ch_sat, ch_val;

    jt12_acc_sat #(.in_w(16), .out_w(14)) u_ch_sat (.din(sum16), .dout(ch_sat));

    assign ch_val = (bus.dacen && cur_ch == LAST_CH) ? {bus.dac_data, 5'b0} : ch_sat;

    // Stereo mix: channel value scaled by 4, accumulation restarts at channel 0.
    logic signed [acc_w-1:0] mix_term, acc_l, acc_r, acc_l_base, acc_r_base;
    logic signed [acc_w-1:0] acc_l_next, acc_r_next;
    snd_t                    snd_l_sat, snd_r_sat;

    assign mix_term   = {{(acc_w-14){ch_val[13]}}, ch_val} << 2;
    assign acc_l_base = (cur_ch == '0) ? '0 : acc_l;
    assign acc_r_base = (cur_ch == '0) ? '0 : acc_r;
    assign acc_l_next = acc_l_base + (bus.pan[1] ? mix_term : '0);
    assign acc_r_next = acc_r_base + (bus.pan[0] ? mix_term : '0);

    jt12_acc_sat #(.in_w(acc_w), .out_w(16)) u_l_sat (.din(acc_l_next), .dout(snd_l_sat));
    jt12_acc_sat #(.in_w(acc_w), .out_w(16)) u_r_sat (.din(acc_r_next), .dout(snd_r_sat));

    op_t        ch_out_q;
    logic [2:0] ch_num_q;
    logic       ch_valid_q, snd_sample_q;
    snd_t       snd_left_q, snd_right_q;

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt       <= '0;
            grp_cnt      <= GRP_S1;
            synced       <= 1'b0;
            acc_l        <= '0;
            acc_r        <= '0;
            ch_out_q     <= '0;
            ch_num_q     <= '0;
            ch_valid_q   <= 1'b0;
            snd_left_q   <= '0;
            snd_right_q  <= '0;
            snd_sample_q <= 1'b0;
        end else if (bus.clk_en) begin
            ch_cnt       <= cur_ch;
            grp_cnt      <= cur_grp;
            ch_valid_q   <= 1'b0;
            snd_sample_q <= 1'b0;
            if (bus.zero) synced <= 1'b1;

            // A resync drops whatever partial frame was being mixed.
            if (bus.zero) begin
                acc_l <= '0;
                acc_r <= '0;
            end else if (cur_grp == GRP_S4) begin
                acc_l <= acc_l_next;
                acc_r <= acc_r_next;
            end

            if (live && cur_grp == GRP_S4) begin
                ch_out_q   <= ch_val;
                ch_num_q   <= cur_ch;
                ch_valid_q <= 1'b1;
                if (cur_ch == LAST_CH) begin
                    snd_left_q   <= snd_l_sat;
                    snd_right_q  <= snd_r_sat;
                    snd_sample_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ch_out     = ch_out_q;
    assign bus.ch_num     = ch_num_q;
    assign bus.ch_valid   = ch_valid_q;
    assign bus.snd_left   = snd_left_q;
    assign bus.snd_right  = snd_right_q;
    assign bus.snd_sample = snd_sample_q;

endmodule

// File: tb/tb_jt12_acc_mix.sv
// Self-checking bench for jt12_acc_mix: table-driven constant frames with
// hand-derived results, then reset/resync/abort sequences and random frames
// checked against a frame-level reference model through expectation queues.
module tb_jt12_acc_mix;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jt12_acc_mix_if bus ();

    jt12_acc_mix #(.num_ch(6), .acc_w(19)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int op; int alg; int pan; bit dacen; int dac;
        int exp_ch; int exp_ch5; int exp_l; int exp_r;
    } vec_t;
    typedef struct { int num; int val; } ch_exp_t;
    typedef struct { int l; int r; } snd_exp_t;

    ch_exp_t  ch_q[$];
    snd_exp_t snd_q[$];
    int checks = 0;
    int errors = 0;

    int op_tab[24];
    int alg_tab[6];
    int pan_tab[6];
    bit dacen_v;
    int dac_v;
    int last_ch, last_l;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int lo, input int hi);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    // Group index g in slot order: 0=S1, 1=S3, 2=S2, 3=S4.
    function automatic bit carrier(input int alg, input int g);
        case (g)
            0:       return alg == 7;
            1:       return alg >= 5;
            2:       return alg >= 4;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ch_out"},     int'(bus.ch_out), 0);
        check({tag, "_ch_num"},     int'(bus.ch_num), 0);
        check({tag, "_ch_valid"},   int'(bus.ch_valid), 0);
        check({tag, "_snd_left"},   int'(bus.snd_left), 0);
        check({tag, "_snd_right"},  int'(bus.snd_right), 0);
        check({tag, "_snd_sample"}, int'(bus.snd_sample), 0);
    endtask

    // One enabled slot, then 'gap' disabled clocks during which everything must hold.
    task automatic step(input bit z, input int op, input int a, input int p,
                        input bit exp_chv, input bit exp_sndv, input int gap);
        ch_exp_t  ce;
        snd_exp_t se;
        bus.zero      = z;
        bus.op_result = 14'(op);
        bus.alg       = 3'(a);
        bus.pan       = 2'(p);
        bus.dacen     = dacen_v;
        bus.dac_data  = 9'(dac_v);
        bus.clk_en    = 1'b1;
        @(posedge clk); #1;
        bus.clk_en = 1'b0;
        check("ch_valid", int'(bus.ch_valid), int'(exp_chv));
        check("snd_sample", int'(bus.snd_sample), int'(exp_sndv));
        if (exp_chv && ch_q.size() > 0) begin
            ce = ch_q.pop_front();
            last_ch = ce.val;
            check("ch_num", int'(bus.ch_num), ce.num);
            check("ch_out", int'(bus.ch_out), ce.val);
        end
        if (exp_sndv && snd_q.size() > 0) begin
            se = snd_q.pop_front();
            last_l = se.l;
            check("snd_left", int'(bus.snd_left), se.l);
            check("snd_right", int'(bus.snd_right), se.r);
        end
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            check("hold_ch_out", int'(bus.ch_out), last_ch);
            check("hold_ch_valid", int'(bus.ch_valid), int'(exp_chv));
            check("hold_snd_left", int'(bus.snd_left), last_l);
            check("hold_snd_sample", int'(bus.snd_sample), int'(exp_sndv));
        end
    endtask

    // Full frame from op_tab/alg_tab/pan_tab; expectations from the vector or the model.
    task automatic drive_frame(input int gap, input bit use_tab, input vec_t v);
        int l, r, ch, g, sum, val;
        ch_exp_t  ce;
        snd_exp_t se;
        l = 0;
        r = 0;
        for (int s = 0; s < 24; s++) begin
            ch = s % 6;
            g  = s / 6;
            if (g == 3) begin
                if (use_tab) begin
                    val = (v.dacen && ch == 5) ? v.exp_ch5 : v.exp_ch;
                end else begin
                    sum = 0;
                    for (int k = 0; k < 4; k++)
                        if (carrier(alg_tab[ch], k)) sum += op_tab[k*6 + ch];
                    val = sat(sum, -8192, 8191);
                    if (dacen_v && ch == 5) val = dac_v * 32;
                end
                ce.num = ch;
                ce.val = val;
                ch_q.push_back(ce);
                if (pan_tab[ch][1]) l += 4 * val;
                if (pan_tab[ch][0]) r += 4 * val;
                if (ch == 5) begin
                    se.l = use_tab ? v.exp_l : sat(l, -32768, 32767);
                    se.r = use_tab ? v.exp_r : sat(r, -32768, 32767);
                    snd_q.push_back(se);
                end
            end
            step(s == 0, op_tab[s], alg_tab[ch], pan_tab[ch], g == 3, s == 23, gap);
        end
        check("ch_queue_drained", ch_q.size(), 0);
        check("snd_queue_drained", snd_q.size(), 0);
    endtask

    task automatic fill_random(input bit with_dac);
        for (int s = 0; s < 24; s++) op_tab[s] = int'($urandom_range(0, 16383)) - 8192;
        for (int c = 0; c < 6; c++) begin
            alg_tab[c] = int'($urandom_range(0, 7));
            pan_tab[c] = int'($urandom_range(0, 3));
        end
        dacen_v = with_dac;
        dac_v   = int'($urandom_range(0, 511)) - 256;
    endtask

    vec_t vecs[9];
    vec_t none;

    initial begin
        vecs[0] = '{op: 100,   alg: 7, pan: 3, dacen: 0, dac: 0,    exp_ch: 400,   exp_ch5: 400,   exp_l: 9600,   exp_r: 9600};
        vecs[1] = '{op: 1000,  alg: 0, pan: 3, dacen: 0, dac: 0,    exp_ch: 1000,  exp_ch5: 1000,  exp_l: 24000,  exp_r: 24000};
        vecs[2] = '{op: 8191,  alg: 7, pan: 2, dacen: 0, dac: 0,    exp_ch: 8191,  exp_ch5: 8191,  exp_l: 32767,  exp_r: 0};
        vecs[3] = '{op: -8192, alg: 7, pan: 2, dacen: 0, dac: 0,    exp_ch: -8192, exp_ch5: -8192, exp_l: -32768, exp_r: 0};
        vecs[4] = '{op: 500,   alg: 4, pan: 1, dacen: 0, dac: 0,    exp_ch: 1000,  exp_ch5: 1000,  exp_l: 0,      exp_r: 24000};
        vecs[5] = '{op: 300,   alg: 5, pan: 3, dacen: 0, dac: 0,    exp_ch: 900,   exp_ch5: 900,   exp_l: 21600,  exp_r: 21600};
        vecs[6] = '{op: 100,   alg: 7, pan: 3, dacen: 1, dac: 255,  exp_ch: 400,   exp_ch5: 8160,  exp_l: 32767,  exp_r: 32767};
        vecs[7] = '{op: 0,     alg: 0, pan: 3, dacen: 1, dac: -256, exp_ch: 0,     exp_ch5: -8192, exp_l: -32768, exp_r: -32768};
        vecs[8] = '{op: 2000,  alg: 6, pan: 1, dacen: 0, dac: 0,    exp_ch: 6000,  exp_ch5: 6000,  exp_l: 0,      exp_r: 32767};
        none    = '{op: 0, alg: 0, pan: 0, dacen: 0, dac: 0, exp_ch: 0, exp_ch5: 0, exp_l: 0, exp_r: 0};

        // Reset state.
        rst = 1'b1;
        bus.clk_en = 1'b1; bus.zero = 1'b1; bus.op_result = '0; bus.alg = '0;
        bus.pan = '0; bus.dacen = 1'b0; bus.dac_data = '0;
        dacen_v = 1'b0; dac_v = 0; last_ch = 0; last_l = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Table-driven constant frames, back to back.
        foreach (vecs[i]) begin
            for (int s = 0; s < 24; s++) op_tab[s] = vecs[i].op;
            for (int c = 0; c < 6; c++) begin
                alg_tab[c] = vecs[i].alg;
                pan_tab[c] = vecs[i].pan;
            end
            dacen_v = vecs[i].dacen;
            dac_v   = vecs[i].dac;
            drive_frame(0, 1'b1, vecs[i]);
        end

        // Reset in the middle of a frame, then run unsynchronised past the S4 group.
        dacen_v = 1'b0;
        dac_v   = 0;
        for (int s = 0; s < 10; s++) step(s == 0, 100, 7, 3, 1'b0, 1'b0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("mid_reset");
        rst = 1'b0;
        last_ch = 0;
        last_l  = 0;
        for (int s = 0; s < 20; s++) step(1'b0, 100, 7, 3, 1'b0, 1'b0, 0);
        check_outputs_zero("unsynced");

        // First synced frame after reset.
        for (int s = 0; s < 24; s++) op_tab[s] = 100;
        for (int c = 0; c < 6; c++) begin alg_tab[c] = 7; pan_tab[c] = 3; end
        drive_frame(0, 1'b1, vecs[0]);

        // Frame aborted by zero at slot 13: no sample, next frame exact.
        fill_random(1'b0);
        for (int s = 0; s < 13; s++) step(s == 0, 4000, 7, 3, 1'b0, 1'b0, 0);
        drive_frame(0, 1'b0, none);

        // Random frames, then the same frame again with clk_en 1-in-4.
        for (int f = 0; f < 3; f++) begin
            fill_random(f == 2);
            drive_frame(0, 1'b0, none);
        end
        drive_frame(3, 1'b0, none);
        for (int s = 0; s < 24; s++) op_tab[s] = 100;
        for (int c = 0; c < 6; c++) begin alg_tab[c] = 7; pan_tab[c] = 3; end
        dacen_v = 1'b0;
        drive_frame(3, 1'b1, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt12_acc_mix.md
Name: jt12_acc_mix

Overview:
- Operator-output accumulator and stereo mixer, directly downstream of the operator stage.
- Consumes the time-multiplexed 14-bit signed operator output (24 slots per frame: 6 channels x 4 operators).
- Sums carrier operators per channel according to the channel algorithm, applies DAC override and panning, and produces per-channel values plus a saturated 16-bit stereo sample once per frame.

Parameters:
- num_ch, 6, channels per frame; only 6 is supported. A frame is 4*num_ch slots.
- acc_w, 19, width of the left/right mix accumulators.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- clk_en  input  1  slot advance enable; all state updates only when high
- zero  input  1  marks slot 0 of a frame (S1 of channel 0) at this block's input
- op_result  input  14  signed operator output for the current slot; aligned with zero by the upstream top level
- alg  input  3  algorithm of the current slot's channel
- pan  input  2  {left,right} enables of the current slot's channel
- dacen  input  1  DAC replaces channel 5
- dac_data  input  9  signed DAC sample
- ch_out  output  14  saturated signed channel sum
- ch_num  output  3  channel index of ch_out
- ch_valid  output  1  one-clk_en pulse qualifying ch_out
- snd_left  output  16  signed left sample
- snd_right  output  16  signed right sample
- snd_sample  output  1  one-clk_en pulse when snd_left/snd_right update

Behaviour:
- Reset: every output is 0, all counters and accumulators are 0, and synced is 0.
- Slot counters:
  - ch_cnt runs 0..5 and grp_cnt runs 0..3; group order is S1, S3, S2, S4.
  - On clk_en with zero=1, both counters load 0 and synced is set to 1.
  - Otherwise, on clk_en, ch_cnt increments; when ch_cnt wraps 5->0, grp_cnt increments, with wrap 3->0.
  - A zero arriving mid-frame resynchronises immediately and the partial frame is discarded: the mix accumulators clear and no snd_sample is issued for it.
- Carrier mask, indexed by {S1,S3,S2,S4}:
  - alg 0-3: S4 only.
  - alg 4: S2 and S4.
  - alg 5-6: S3, S2, S4.
  - alg 7: all four.
  - A non-carrier slot contributes 0.
- Channel sums:
  - A 6-stage, 16-bit shift buffer holds the partial sums, advancing on clk_en.
  - In the S1 group the stored sum is replaced by the contribution, not added to.
  - Contributions are sign-extended to 16 bits.
- Channel completion (S4 slot):
  - The sum is the buffered sum plus the contribution, saturated to [-8192, 8191].
  - If dacen=1 and ch_cnt=5, the value is {dac_data, 5'b0} instead.
  - One clk_en later: ch_out holds the value, ch_num=ch_cnt, and ch_valid=1 for exactly one clk_en cycle.
- Mix:
  - In each S4 slot, the completed value, sign-extended and shifted left by 2, is added to the left accumulator if pan[1]=1 and to the right accumulator if pan[0]=1.
  - Accumulators are acc_w bits wide and cleared at the first S4 slot (ch_cnt=0).
  - At the last slot (grp=3, ch=5), including that slot's contribution, snd_left/snd_right are loaded one clk_en later, saturated to [-32768, 32767], and snd_sample pulses for one clk_en cycle.
- While synced=0:
  - ch_valid and snd_sample stay 0.
  - Outputs hold their reset values.
- Between updates, all outputs hold their values; clk_en=0 freezes everything, including the pulses, which stay high until the next clk_en.

Decomposition:
- Shared package:
  - carrier-mask constant table (8 entries x 4 bits);
  - group encoding constants GRP_S1=0, GRP_S3=1, GRP_S2=2, GRP_S4=3;
  - saturation limits for 14 and 16 bits.
- Sub-module jt12_acc_sat: parameterised signed saturator (input width, output width), instantiated for the channel path and for each stereo path.
- The 6-stage buffer reuses the existing jt12_sh shift register.

Test Plan:
- Reset mid-frame, then zero, then 24 slots with op_result=100, alg=7, pan=2'b11 -> each ch_out=400; snd_left=snd_right=4*6*400=9600; snd_sample pulses once, one clk_en after slot 23.
- alg=0, op_result=1000 in every slot -> ch_out=1000 for ch 0..5, and ch_num sequences 0..5 in the S4 group.
- alg=7, op_result=8191 in every slot -> ch_out saturates to 8191; with pan=2'b10, snd_left=32767 (saturated) and snd_right=0.
- alg=7, op_result=-8192 -> ch_out=-8192 and snd_left=-32768.
- dacen=1, dac_data=9'h0FF, ch5 op_result=0 -> ch5 ch_out=8160, other channels unaffected.
- zero reasserted at slot 13 -> no snd_sample for the aborted frame; counters restart at slot 0; the next full frame produces correct sums; clk_en toggling 1-in-4 produces identical results.
